rs485_packet_rx: RTL



---
 rtl/rs485_packet_rx_pkg.sv | 54 +++++
 rtl/rs485_packet_rx_uart.sv | 157 +++++++++++++++
 rtl/rs485_packet_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rs485_packet_rx_pkg.sv
// ---------------------------------------------------------------------------
// rs485_packet_rx_pkg
// Definitions shared by the RS485 packet receiver and its byte receiver.
//   ckrs_t           : clock/reset record (rising-edge clock, sync active-high
//                      reset)
//   CTRL_* / ST_*    : control and status register bit positions
//   rx_state_t       : byte receiver states
//   status_flags_t   : flag field of the status word, bits [20:16]
//   byte_mask()      : write-enable mask for a word holding n valid bytes
// ---------------------------------------------------------------------------
package rs485_packet_rx_pkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CLEAR  = 1;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_DONE      = 16;
    localparam int ST_OVERFLOW  = 17;
    localparam int ST_FERR      = 18;
    localparam int ST_BUSY      = 19;
    localparam int ST_PERR      = 20;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Field order matches status bits 20 (msb) down to 16 (lsb).
    typedef struct packed {
        logic perr;
        logic busy;
        logic ferr;
        logic overflow;
        logic done;
    } status_flags_t;

    function automatic logic [3:0] byte_mask(input logic [1:0] nbytes);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(nbytes)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rs485_packet_rx_uart.sv
// ---------------------------------------------------------------------------
// rs485_uart_rx
// Asynchronous byte receiver: 2-FF input synchronizer, bit timer and frame
// FSM. Frames are 8N1, or 8E1 when RS485_RX_PARITY_EN is defined.
// Ports:
//   clk, srst    : clock, synchronous active-high reset
//   enable       : allows a new frame to start (a running frame completes)
//   abort        : drops any frame in flight and returns to idle
//   rx           : raw asynchronous receive line, idle high
//   byte_o       : received byte, valid while valid_o is high
//   valid_o      : one-cycle pulse in the stop-bit sample cycle of a good frame
//   ferr_o       : one-cycle pulse when the stop bit is sampled low
//   perr_o       : one-cycle pulse on even-parity mismatch (0 without parity)
//   line_idle_o  : receiver idle and synchronized line high
// ---------------------------------------------------------------------------
module rs485_uart_rx
    import rs485_packet_rx_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       enable,
    input  logic       abort,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       ferr_o,
    output logic       perr_o,
    output logic       line_idle_o
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BAUD_DIV - 1);

    logic            rx_meta_reg;
    logic            rx_sync_reg;
    rx_state_t       state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shift_reg, shift_next;
`ifdef RS485_RX_PARITY_EN
    logic            par_bad_reg, par_bad_next;
`endif

    logic tick;
    assign tick = (timer_reg == '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
`ifdef RS485_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
`ifdef RS485_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
`ifdef RS485_RX_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        valid_o = 1'b0;
        ferr_o  = 1'b0;
        perr_o  = 1'b0;

        case (state_reg)
            RX_IDLE: begin
                if (enable && !rx_sync_reg) begin
                    state_next = RX_START;
                    timer_next = HALF_LOAD;
                end
            end
            RX_START: begin
                if (!tick) begin
                    timer_next = timer_reg - TW'(1);
                end else if (rx_sync_reg) begin
                    state_next = RX_IDLE;      // start-bit glitch, silently dropped
                end else begin
                    state_next   = RX_DATA;
                    timer_next   = BIT_LOAD;
                    bit_cnt_next = '0;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    timer_next = timer_reg - TW'(1);
                end else begin
                    shift_next   = {rx_sync_reg, shift_reg[7:1]};
                    timer_next   = BIT_LOAD;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef RS485_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef RS485_RX_PARITY_EN
            RX_PARITY: begin
                if (!tick) begin
                    timer_next = timer_reg - TW'(1);
                end else begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_bad_next = ^{shift_reg, rx_sync_reg};
                    timer_next   = BIT_LOAD;
                    state_next   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (!tick) begin
                    timer_next = timer_reg - TW'(1);
                end else begin
                    state_next = RX_IDLE;
                    if (!rx_sync_reg) begin
                        ferr_o = 1'b1;
`ifdef RS485_RX_PARITY_EN
                    end else if (par_bad_reg) begin
                        perr_o = 1'b1;
`endif
                    end else begin
                        valid_o = 1'b1;
                    end
                end
            end
            default: state_next = RX_IDLE;
        endcase

        if (abort) state_next = RX_IDLE;
    end

    assign byte_o      = shift_reg;
    assign line_idle_o = (state_reg == RX_IDLE) && rx_sync_reg;

endmodule

// File: rtl/rs485_packet_rx.sv
// ---------------------------------------------------------------------------
// rs485_packet_rx
// Receives RS485 serial bytes, packs them little-endian into 32-bit words and
// writes them to the packet buffer. A packet ends after IDLE_BITS bit times
// of idle line; a partial word is then flushed with a byte-enable mask.
// Optional even parity: define RS485_RX_PARITY_EN.
// Ports:
//   ClkRs_ix   : clock (rising edge) and synchronous active-high reset
//   rx_i       : asynchronous receive line, idle high
//   buf_en_o   : buffer write strobe (one cycle per write)
//   buf_we_o   : per-byte write enables
//   buf_addr_o : word-aligned byte address
//   buf_din_o  : write data
//   control_i  : [0] enable, [1] clear (rising edge)
//   status_o   : [15:0] words written, [16] done, [17] overflow,
//                [18] framing error, [19] busy, [20] parity error
//   done_o     : one-cycle pulse when a packet terminates
// ---------------------------------------------------------------------------
module rs485_packet_rx
    import rs485_packet_rx_pkg::*;
#(
    parameter int BAUD_DIV  = 868,
    parameter int IDLE_BITS = 4,
    parameter int BUF_WORDS = 1024
) (
    input  ckrs_t       ClkRs_ix,
    input  logic        rx_i,
    output logic        buf_en_o,
    output logic [3:0]  buf_we_o,
    output logic [31:0] buf_addr_o,
    output logic [31:0] buf_din_o,
    input  logic [31:0] control_i,
    output logic [31:0] status_o,
    output logic        done_o
);

    localparam int IDLE_LIMIT = IDLE_BITS * BAUD_DIV;
    localparam int IW = $clog2(IDLE_LIMIT + 1);
    localparam int WW = $clog2(BUF_WORDS + 1);

    logic clk;
    logic srst;
    assign clk  = ClkRs_ix.clk;
    assign srst = ClkRs_ix.reset;

    logic enable;
    logic clear_prev_reg;
    logic clear_edge;
    logic ctrl_unused;
    assign enable      = control_i[CTRL_ENABLE];
    assign clear_edge  = control_i[CTRL_CLEAR] & ~clear_prev_reg;
    assign ctrl_unused = ^control_i[31:2];

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_perr;
    logic       line_idle;

    rs485_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_rx (
        .clk         (clk),
        .srst        (srst),
        .enable      (enable),
        .abort       (clear_edge),
        .rx          (rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .ferr_o      (rx_ferr),
        .perr_o      (rx_perr),
        .line_idle_o (line_idle)
    );

    logic [WW-1:0] word_idx_reg,   word_idx_next;
    logic [1:0]    byte_idx_reg,   byte_idx_next;
    logic [31:0]   partial_reg,    partial_next;
    logic [IW-1:0] idle_cnt_reg,   idle_cnt_next;
    logic          have_bytes_reg, have_bytes_next;
    logic          done_reg,       done_next;
    logic          ovf_reg,        ovf_next;
    logic          ferr_reg,       ferr_next;
    logic          perr_reg,       perr_next;
    logic          buf_en_reg,     buf_en_next;
    logic [3:0]    buf_we_reg,     buf_we_next;
    logic [31:0]   buf_addr_reg,   buf_addr_next;
    logic [31:0]   buf_din_reg,    buf_din_next;
    logic          done_pulse_reg, done_pulse_next;

    logic        idle_expire;
    logic [31:0] word_addr;
    assign idle_expire = have_bytes_reg && !done_reg && (idle_cnt_reg == IW'(IDLE_LIMIT));
    assign word_addr   = 32'(word_idx_reg) << 2;

    always_ff @(posedge clk) begin
        if (srst) begin
            clear_prev_reg <= 1'b0;
            word_idx_reg   <= '0;
            byte_idx_reg   <= '0;
            partial_reg    <= '0;
            idle_cnt_reg   <= '0;
            have_bytes_reg <= 1'b0;
            done_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            ferr_reg       <= 1'b0;
            perr_reg       <= 1'b0;
            buf_en_reg     <= 1'b0;
            buf_we_reg     <= '0;
            buf_addr_reg   <= '0;
            buf_din_reg    <= '0;
            done_pulse_reg <= 1'b0;
        end else begin
            clear_prev_reg <= control_i[CTRL_CLEAR];
            word_idx_reg   <= word_idx_next;
            byte_idx_reg   <= byte_idx_next;
            partial_reg    <= partial_next;
            idle_cnt_reg   <= idle_cnt_next;
            have_bytes_reg <= have_bytes_next;
            done_reg       <= done_next;
            ovf_reg        <= ovf_next;
            ferr_reg       <= ferr_next;
            perr_reg       <= perr_next;
            buf_en_reg     <= buf_en_next;
            buf_we_reg     <= buf_we_next;
            buf_addr_reg   <= buf_addr_next;
            buf_din_reg    <= buf_din_next;
            done_pulse_reg <= done_pulse_next;
        end
    end

    always_comb begin
        word_idx_next   = word_idx_reg;
        byte_idx_next   = byte_idx_reg;
        partial_next    = partial_reg;
        idle_cnt_next   = idle_cnt_reg;
        have_bytes_next = have_bytes_reg;
        done_next       = done_reg;
        ovf_next        = ovf_reg;
        ferr_next       = ferr_reg;
        perr_next       = perr_reg;
        buf_en_next     = 1'b0;
        buf_we_next     = 4'b0000;
        buf_addr_next   = buf_addr_reg;
        buf_din_next    = buf_din_reg;
        done_pulse_next = 1'b0;

        if (clear_edge) begin
            // Clear overrides everything this cycle, including a pending write.
            word_idx_next   = '0;
            byte_idx_next   = '0;
            partial_next    = '0;
            idle_cnt_next   = '0;
            have_bytes_next = 1'b0;
            done_next       = 1'b0;
            ovf_next        = 1'b0;
            ferr_next       = 1'b0;
            perr_next       = 1'b0;
        end else begin
            if (rx_ferr) ferr_next = 1'b1;
            if (rx_perr) perr_next = 1'b1;

            if (idle_expire) begin
                done_next       = 1'b1;
                done_pulse_next = 1'b1;
                have_bytes_next = 1'b0;
                idle_cnt_next   = '0;
                byte_idx_next   = '0;
                partial_next    = '0;
                if (byte_idx_reg != 2'd0) begin
                    buf_en_next   = 1'b1;
                    buf_we_next   = byte_mask(byte_idx_reg);
                    buf_addr_next = word_addr;
                    buf_din_next  = partial_reg;
                    word_idx_next = word_idx_reg + WW'(1);
                end
            end else if (rx_valid && !done_reg) begin
                have_bytes_next = 1'b1;
                idle_cnt_next   = '0;
                if (word_idx_reg == WW'(BUF_WORDS)) begin
                    ovf_next = 1'b1;
                end else begin
                    partial_next[{byte_idx_reg, 3'b000} +: 8] = rx_byte;
                    if (byte_idx_reg == 2'd3) begin
                        buf_en_next   = 1'b1;
                        buf_we_next   = 4'b1111;
                        buf_addr_next = word_addr;
                        buf_din_next  = partial_next;
                        partial_next  = '0;
                        byte_idx_next = '0;
                        word_idx_next = word_idx_reg + WW'(1);
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end
            end else if (have_bytes_reg && !done_reg && line_idle) begin
                idle_cnt_next = idle_cnt_reg + IW'(1);
            end else begin
                idle_cnt_next = '0;
            end
        end
    end

    status_flags_t flags;
    assign flags = '{perr: perr_reg, busy: have_bytes_reg, ferr: ferr_reg,
                     overflow: ovf_reg, done: done_reg};

    assign status_o   = {11'b0, flags, 16'(word_idx_reg)};
    assign buf_en_o   = buf_en_reg;
    assign buf_we_o   = buf_we_reg;
    assign buf_addr_o = buf_addr_reg;
    assign buf_din_o  = buf_din_reg;
    assign done_o     = done_pulse_reg;

endmodule
